// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: Funct3 access sizes, FSM states
// and the alignment legality check used by the top-level FSM.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } lsu_state_e;

  // Undefined Funct3 encodings are treated as illegal, same as misaligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication and byte enables, load lane select
// and sign/zero extension. Purely combinational.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] st_lanes_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_lanes_o = st_data_i;
    st_be_o    = 4'b1111;
    case (st_funct3_i[1:0])
      2'b00: begin
        st_lanes_o = {4{st_data_i[7:0]}};
        st_be_o    = 4'b0001 << st_off_i;
      end
      2'b01: begin
        st_lanes_o = {2{st_data_i[15:0]}};
        st_be_o    = 4'b0011 << st_off_i;
      end
      default: ;
    endcase
  end

  assign ld_byte = ld_word_i[{ld_off_i, 3'b000} +: 8];
  assign ld_half = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

  always_comb begin
    ld_data_o = ld_word_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'b0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'b0, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: IDLE/BUSY/DONE bus sequencer with timeout, stalls the
// pipeline for the whole bus transaction and releases it for one DONE cycle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      data_q;
  logic             berr_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic        access;
  logic        misalign;
  logic [31:0] st_lanes;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  assign access   = MemReadM | MemWriteM;
  assign misalign = is_misaligned(Funct3M, ALUResultM[1:0]);

  lsu_align u_align (
    .st_funct3_i (Funct3M),
    .st_off_i    (ALUResultM[1:0]),
    .st_data_i   (WriteDataM),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_word_i   (mem_rdata),
    .st_lanes_o  (st_lanes),
    .st_be_o     (st_be),
    .ld_data_o   (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      berr_q    <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access && !misalign) begin
            state_q   <= ST_BUSY;
            cnt_q     <= '0;
            berr_q    <= 1'b0;
            f3_q      <= Funct3M;
            off_q     <= ALUResultM[1:0];
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUResultM[31:2], 2'b00};
            mem_wdata <= st_lanes;
            mem_be    <= st_be;
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            state_q <= ST_DONE;
            mem_req <= 1'b0;
            data_q  <= mem_we ? '0 : ld_data;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q <= ST_DONE;
            mem_req <= 1'b0;
            data_q  <= '0;
            berr_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stall asserts combinationally in IDLE so the access is held in M until accepted.
  assign StallM    = (state_q == ST_BUSY) || ((state_q == ST_IDLE) && access && !misalign);
  assign MisalignM = (state_q == ST_IDLE) && access && misalign;
  assign BusErrM   = (state_q == ST_DONE) && berr_q;
  assign ReadDataM = (state_q == ST_DONE) ? data_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit: a bus responder with programmable ack
// delay, expected results queued at issue and compared in the DONE cycle.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] exp_q[$];

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one access, play the bus slave, and score the DONE cycle.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdat, input int ack_dly,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic [31:0] e_rd);
    int stall_cyc;
    int req_cyc;
    bit done;
    bit tmo;
    logic [32:0] e;
    tmo = (ack_dly >= TO);
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    exp_q.push_back({tmo, tmo ? 32'h0 : e_rd});
    stall_cyc = 0; req_cyc = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (StallM) begin
        stall_cyc++;
        if (mem_req) begin
          check_eq({name, "_addr"}, mem_addr, e_addr);
          check_eq({name, "_be"}, {28'h0, mem_be}, {28'h0, e_be});
          check_eq({name, "_we"}, {31'h0, mem_we}, {31'h0, wr});
          if (wr) check_eq({name, "_wdata"}, mem_wdata, e_wd);
          mem_ack   = (req_cyc == ack_dly);
          mem_rdata = rdat;
          req_cyc++;
        end else begin
          mem_ack = 1'b0;
        end
        @(negedge clk);
      end else begin
        done = 1;
        mem_ack = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0;
        if (exp_q.size() == 0) begin
          check_eq({name, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check_eq({name, "_rdata"}, ReadDataM, e[31:0]);
          check_eq({name, "_buserr"}, {31'h0, BusErrM}, {31'h0, e[32]});
        end
        check_eq({name, "_req_done"}, {31'h0, mem_req}, 32'h0);
      end
    end
    if (!done) begin
      check_eq({name, "_no_done"}, 32'h0, 32'h1);
      MemReadM = 1'b0; MemWriteM = 1'b0; mem_ack = 1'b0;
    end
    check_eq({name, "_stall_cyc"}, stall_cyc, tmo ? 1 + TO : 2 + ack_dly);
    check_eq({name, "_req_cyc"}, req_cyc, tmo ? TO : ack_dly + 1);
    @(negedge clk);
    #1;
    check_eq({name, "_idle_rd"}, ReadDataM, 32'h0);
    check_eq({name, "_idle_stall"}, {31'h0, StallM}, 32'h0);
    check_eq({name, "_idle_berr"}, {31'h0, BusErrM}, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    int dly;
    reset = 1'b1;
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = 32'h0; WriteDataM = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    check_eq("rst_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst_addr", mem_addr, 32'h0);
    check_eq("rst_be", {28'h0, mem_be}, 32'h0);
    check_eq("rst_wdata", mem_wdata, 32'h0);
    check_eq("rst_stall", {31'h0, StallM}, 32'h0);
    check_eq("rst_rdata", ReadDataM, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_txn("sb", 1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1,
            32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0);
    run_txn("lb", 1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_F000, 0,
            32'h0000_2000, 4'b0010, 32'h0, 32'hFFFF_FFF0);
    run_txn("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_F000, 2,
            32'h0000_2000, 4'b0010, 32'h0, 32'h0000_00F0);
    run_txn("lh", 1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 0,
            32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001);
    run_txn("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 1,
            32'h0000_2000, 4'b1100, 32'h0, 32'h0000_8001);
    run_txn("lw", 1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0,
            32'h0000_4000, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    run_txn("sh_both", 1'b1, 1'b1, 3'b001, 32'h0000_0002, 32'h0000_1234, 32'h5555_5555, 0,
            32'h0000_0000, 4'b1100, 32'h1234_1234, 32'h0);
    run_txn("lw_tmo", 1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h0, 1000,
            32'h0000_6000, 4'b1111, 32'h0, 32'h0);

    // Misaligned word load: flag only, no bus traffic.
    @(negedge clk);
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_3002;
    #1;
    check_eq("mis_flag", {31'h0, MisalignM}, 32'h1);
    check_eq("mis_stall", {31'h0, StallM}, 32'h0);
    check_eq("mis_rdata", ReadDataM, 32'h0);
    @(negedge clk);
    MemReadM = 1'b0;
    #1;
    check_eq("mis_req", {31'h0, mem_req}, 32'h0);
    check_eq("mis_flag_clr", {31'h0, MisalignM}, 32'h0);

    // Reset in the middle of BUSY, then a stray ack.
    @(negedge clk);
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_7000;
    @(negedge clk);
    #1;
    check_eq("mid_busy_req", {31'h0, mem_req}, 32'h1);
    reset = 1'b1; MemReadM = 1'b0;
    #1;
    check_eq("async_rst_req", {31'h0, mem_req}, 32'h0);
    check_eq("async_rst_stall", {31'h0, StallM}, 32'h0);
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check_eq("late_ack_req", {31'h0, mem_req}, 32'h0);
    check_eq("late_ack_stall", {31'h0, StallM}, 32'h0);
    check_eq("late_ack_rdata", ReadDataM, 32'h0);
    run_txn("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 32'h0BAD_F00D, 1,
            32'h0000_7000, 4'b1111, 32'h0, 32'h0BAD_F00D);

    for (int i = 0; i < 4; i++) begin
      ra  = {$urandom_range(0, 32'h3FFF), 2'b00};
      rd  = $urandom;
      dly = $urandom_range(0, 2);
      run_txn("rnd_sw", 1'b0, 1'b1, 3'b010, ra, rd, 32'h0, dly, ra, 4'b1111, rd, 32'h0);
      run_txn("rnd_lw", 1'b1, 1'b0, 3'b010, ra, 32'h0, rd, dly, ra, 4'b1111, 32'h0, rd);
    end

    check_eq("sb_leftover", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
